alarm_controller: RTL and testbench

Top-level sequencer for the home alarm. Consumes the 2-bit code-check result from the key checker and the door/window sensor, and runs the arm/disarm state machine. Provides exit/entry delays, a wrong-code attempt limit with lockout, and siren control. Sits between the key checker and the output drivers (siren, LEDs), clocked by the system clock.

---
 rtl/alarm_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_alarm_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
//
// Top-level sequencer for the home alarm. Takes the key checker's 2-bit code
// result and the door/window sensor, and runs the arm/disarm state machine
// with exit/entry delays, a consecutive wrong-code limit with lockout, and
// siren control.
//
// Parameters
//   TICK_DIV      clk cycles per 1 s timer tick (>= 2)
//   EXIT_TIME     seconds from valid arm code to ARMED
//   ENTRY_TIME    seconds from sensor trip to ALARM
//   MAX_ERRORS    consecutive ERROR results that trigger lockout/alarm (1..15)
//   LOCKOUT_TIME  seconds code results are ignored after lockout
//   SIREN_TIME    seconds of siren before auto-rearm (SIREN_TIMEOUT_EN only)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   keyStatus  in 2 key checker result: OK=0, ERROR=2, NOKEY=3 (1 = NOKEY);
//                   asynchronous to clk
//   sensor     in   door/window open = 1; asynchronous level
//   siren      out  siren drive (ALARM)
//   armed      out  ARMED, ENTRY_DELAY or ALARM
//   pending    out  EXIT_DELAY or ENTRY_DELAY (buzzer/blink)
//   lockout    out  LOCKOUT
//   state      out 3 state code for debug
//   errCount   out 4 current consecutive-error count
//
// Build option
//   SIREN_TIMEOUT_EN  when defined, ALARM times out after SIREN_TIME seconds
//                     and re-arms (siren off, error count cleared). When not
//                     defined, ALARM is left only by a valid code or reset.
// ---------------------------------------------------------------------------
module alarm_controller #(
    parameter int TICK_DIV     = 12_000_000,
    parameter int EXIT_TIME    = 20,
    parameter int ENTRY_TIME   = 15,
    parameter int MAX_ERRORS   = 3,
    parameter int LOCKOUT_TIME = 60,
    parameter int SIREN_TIME   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] keyStatus,
    input  logic       sensor,
    output logic       siren,
    output logic       armed,
    output logic       pending,
    output logic       lockout,
    output logic [2:0] state,
    output logic [3:0] errCount
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] KEY_OK    = 2'd0;
    localparam logic [1:0] KEY_ERROR = 2'd2;
    localparam logic [1:0] KEY_NOKEY = 2'd3;

    // The seconds counter is sized for the longest duration it may ever hold,
    // including the siren duration so the width does not change between builds.
    localparam int MAX_T_A  = (EXIT_TIME > ENTRY_TIME) ? EXIT_TIME : ENTRY_TIME;
    localparam int MAX_T_B  = (LOCKOUT_TIME > SIREN_TIME) ? LOCKOUT_TIME : SIREN_TIME;
    localparam int MAX_TIME = (MAX_T_A > MAX_T_B) ? MAX_T_A : MAX_T_B;
    localparam int SEC_W    = $clog2(MAX_TIME + 1);
    localparam int PRE_W    = $clog2(TICK_DIV);

    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]       ERR_MAX = 4'(MAX_ERRORS);

    typedef enum logic [2:0] {
        S_DISARMED    = 3'd0,
        S_EXIT_DELAY  = 3'd1,
        S_ARMED       = 3'd2,
        S_ENTRY_DELAY = 3'd3,
        S_ALARM       = 3'd4,
        S_LOCKOUT     = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers and result-event detection
    // -----------------------------------------------------------------------
    logic [1:0] key_meta_reg;
    logic [1:0] key_sync_reg;
    logic [1:0] key_prev_reg;
    logic       sens_meta_reg;
    logic       sens_sync_reg;
    logic [1:0] key_norm;
    logic       ok_event;
    logic       err_event;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_reg  <= KEY_NOKEY;
            key_sync_reg  <= KEY_NOKEY;
            key_prev_reg  <= KEY_NOKEY;
            sens_meta_reg <= 1'b0;
            sens_sync_reg <= 1'b0;
        end else begin
            key_meta_reg  <= keyStatus;
            key_sync_reg  <= key_meta_reg;
            key_prev_reg  <= key_norm;
            sens_meta_reg <= sensor;
            sens_sync_reg <= sens_meta_reg;
        end
    end

    // Code 1 is not a real result; fold it into NOKEY so it also re-enables
    // event detection like a released key.
    assign key_norm  = (key_sync_reg == 2'd1) ? KEY_NOKEY : key_sync_reg;

    // A result fires only on the NOKEY -> result step, so a held key is one event.
    assign ok_event  = (key_norm == KEY_OK)    && (key_prev_reg == KEY_NOKEY);
    assign err_event = (key_norm == KEY_ERROR) && (key_prev_reg == KEY_NOKEY);

    // -----------------------------------------------------------------------
    // State / error count
    // -----------------------------------------------------------------------
    state_t     state_reg;
    state_t     state_next;
    logic [3:0] err_reg;
    logic [3:0] err_next;
    logic [3:0] err_inc;
    logic       err_limit;
    logic [3:0] err_alarm;

    assign err_inc   = (err_reg == 4'hF) ? err_reg : err_reg + 4'd1;
    assign err_limit = (err_inc >= ERR_MAX);
    // In ALARM the count keeps growing but never past the limit.
    assign err_alarm = err_limit ? ERR_MAX : err_inc;

    // -----------------------------------------------------------------------
    // Seconds timer with prescaler
    // -----------------------------------------------------------------------
    logic [SEC_W-1:0] sec_reg;
    logic [PRE_W-1:0] pre_reg;
    logic             timer_run;
    logic             timer_load;
    logic [SEC_W-1:0] timer_load_val;
    logic             expire;

    // Which states count down while resident.
    always_comb begin
        timer_run = 1'b0;
        case (state_reg)
            S_EXIT_DELAY,
            S_ENTRY_DELAY,
            S_LOCKOUT:     timer_run = 1'b1;
`ifdef SIREN_TIMEOUT_EN
            S_ALARM:       timer_run = 1'b1;
`endif
            default:       timer_run = 1'b0;
        endcase
    end

    // Load on entry into a timed state; the prescaler restarts from zero so
    // expiry lands exactly N*TICK_DIV cycles after the entry edge.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = '0;
        if (state_next != state_reg) begin
            case (state_next)
                S_EXIT_DELAY: begin
                    timer_load     = 1'b1;
                    timer_load_val = SEC_W'(EXIT_TIME);
                end
                S_ENTRY_DELAY: begin
                    timer_load     = 1'b1;
                    timer_load_val = SEC_W'(ENTRY_TIME);
                end
                S_LOCKOUT: begin
                    timer_load     = 1'b1;
                    timer_load_val = SEC_W'(LOCKOUT_TIME);
                end
`ifdef SIREN_TIMEOUT_EN
                S_ALARM: begin
                    timer_load     = 1'b1;
                    timer_load_val = SEC_W'(SIREN_TIME);
                end
`endif
                default: begin
                    timer_load     = 1'b0;
                    timer_load_val = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_reg <= '0;
            pre_reg <= '0;
        end else if (timer_load) begin
            sec_reg <= timer_load_val;
            pre_reg <= '0;
        end else if (timer_run) begin
            if (pre_reg == PRE_TOP) begin
                pre_reg <= '0;
                if (sec_reg != '0) begin
                    sec_reg <= sec_reg - SEC_W'(1);
                end
            end else begin
                pre_reg <= pre_reg + PRE_W'(1);
            end
        end else begin
            sec_reg <= '0;
            pre_reg <= '0;
        end
    end

    // Expiry is the prescaler wrap that would take the last second to zero.
    assign expire = timer_run && (pre_reg == PRE_TOP) && (sec_reg == SEC_W'(1));

    // -----------------------------------------------------------------------
    // Next-state logic. Priority: OK, ERROR at limit, expiry, sensor.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        case (state_reg)
            S_DISARMED: begin
                if (ok_event) begin
                    state_next = S_EXIT_DELAY;
                    err_next   = '0;
                end else if (err_event) begin
                    err_next = err_inc;
                    if (err_limit) begin
                        state_next = S_LOCKOUT;
                    end
                end
            end
            S_EXIT_DELAY: begin
                if (ok_event) begin
                    state_next = S_DISARMED;
                    err_next   = '0;
                end else begin
                    if (err_event) begin
                        err_next = err_inc;
                    end
                    if (err_event && err_limit) begin
                        state_next = S_ALARM;
                    end else if (expire) begin
                        state_next = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (ok_event) begin
                    state_next = S_DISARMED;
                    err_next   = '0;
                end else begin
                    if (err_event) begin
                        err_next = err_inc;
                    end
                    if (err_event && err_limit) begin
                        state_next = S_ALARM;
                    end else if (sens_sync_reg) begin
                        state_next = S_ENTRY_DELAY;
                    end
                end
            end
            S_ENTRY_DELAY: begin
                if (ok_event) begin
                    state_next = S_DISARMED;
                    err_next   = '0;
                end else begin
                    if (err_event) begin
                        err_next = err_inc;
                    end
                    if (err_event && err_limit) begin
                        state_next = S_ALARM;
                    end else if (expire) begin
                        state_next = S_ALARM;
                    end
                end
            end
            S_ALARM: begin
                if (ok_event) begin
                    state_next = S_DISARMED;
                    err_next   = '0;
                end else begin
                    if (err_event) begin
                        err_next = err_alarm;
                    end
`ifdef SIREN_TIMEOUT_EN
                    // Auto-rearm; a sensor still open restarts via ENTRY_DELAY.
                    if (expire) begin
                        state_next = S_ARMED;
                        err_next   = '0;
                    end
`endif
                end
            end
            S_LOCKOUT: begin
                // Code results are ignored for the whole lockout period.
                if (expire) begin
                    state_next = S_DISARMED;
                    err_next   = '0;
                end
            end
            default: begin
                state_next = S_DISARMED;
                err_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state, registered alongside the state.
    // -----------------------------------------------------------------------
    logic [5:1] state_dec_next;

    genvar gi;
    generate
        for (gi = 1; gi <= 5; gi++) begin : g_state_dec
            assign state_dec_next[gi] = (state_next == state_t'(gi));
        end
    endgenerate

    logic siren_next;
    logic armed_next;
    logic pending_next;
    logic lockout_next;

    always_comb begin
        siren_next   = state_dec_next[S_ALARM];
        armed_next   = state_dec_next[S_ARMED] | state_dec_next[S_ENTRY_DELAY]
                     | state_dec_next[S_ALARM];
        pending_next = state_dec_next[S_EXIT_DELAY] | state_dec_next[S_ENTRY_DELAY];
        lockout_next = state_dec_next[S_LOCKOUT];
    end

    logic siren_reg;
    logic armed_reg;
    logic pending_reg;
    logic lockout_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_DISARMED;
            err_reg     <= '0;
            siren_reg   <= 1'b0;
            armed_reg   <= 1'b0;
            pending_reg <= 1'b0;
            lockout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_reg     <= err_next;
            siren_reg   <= siren_next;
            armed_reg   <= armed_next;
            pending_reg <= pending_next;
            lockout_reg <= lockout_next;
        end
    end

    assign siren    = siren_reg;
    assign armed    = armed_reg;
    assign pending  = pending_reg;
    assign lockout  = lockout_reg;
    assign state    = state_reg;
    assign errCount = err_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_controller
//
// Self-checking bench for alarm_controller. A cycle-level reference model
// (input delay line, state as an integer, timer as an absolute deadline cycle)
// is compared against every DUT output after every clock edge. Directed
// scenarios follow the test plan, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_alarm_controller;

    localparam int P_TICK    = 4;
    localparam int P_EXIT    = 2;
    localparam int P_ENTRY   = 3;
    localparam int P_MAX     = 3;
    localparam int P_LOCKOUT = 5;
    localparam int P_SIREN   = 2;

    localparam int M_DIS   = 0;
    localparam int M_EXIT  = 1;
    localparam int M_ARMED = 2;
    localparam int M_ENTRY = 3;
    localparam int M_ALARM = 4;
    localparam int M_LOCK  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] keyStatus = 2'd3;
    logic       sensor = 1'b0;
    logic       siren;
    logic       armed;
    logic       pending;
    logic       lockout;
    logic [2:0] state;
    logic [3:0] errCount;

    int total = 0;
    int bad   = 0;

    alarm_controller #(
        .TICK_DIV    (P_TICK),
        .EXIT_TIME   (P_EXIT),
        .ENTRY_TIME  (P_ENTRY),
        .MAX_ERRORS  (P_MAX),
        .LOCKOUT_TIME(P_LOCKOUT),
        .SIREN_TIME  (P_SIREN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .keyStatus(keyStatus),
        .sensor   (sensor),
        .siren    (siren),
        .armed    (armed),
        .pending  (pending),
        .lockout  (lockout),
        .state    (state),
        .errCount (errCount)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    int         m_state    = M_DIS;
    int         m_err      = 0;
    int         m_cycle    = 0;
    int         m_deadline = -1;
    logic [1:0] kh1 = 2'd3, kh2 = 2'd3, kh3 = 2'd3;
    logic       sh1 = 1'b0, sh2 = 1'b0;

    function automatic int dur_of(input int st);
        case (st)
            M_EXIT:  return P_EXIT;
            M_ENTRY: return P_ENTRY;
            M_LOCK:  return P_LOCKOUT;
`ifdef SIREN_TIMEOUT_EN
            M_ALARM: return P_SIREN;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic [1:0] k, input logic s, input logic r);
        int nxt;
        int nerr;
        int inc;
        bit ok_ev;
        bit er_ev;
        bit expd;
        bit reach;
        m_cycle++;
        if (r) begin
            m_state    = M_DIS;
            m_err      = 0;
            m_deadline = -1;
            kh1 = 2'd3; kh2 = 2'd3; kh3 = 2'd3;
            sh1 = 1'b0; sh2 = 1'b0;
        end else begin
            ok_ev = (kh2 == 2'd0) && (kh3 == 2'd3);
            er_ev = (kh2 == 2'd2) && (kh3 == 2'd3);
            expd  = (m_deadline == m_cycle);
            inc   = (m_err < 15) ? m_err + 1 : 15;
            reach = (inc >= P_MAX);
            nxt   = m_state;
            nerr  = m_err;
            case (m_state)
                M_DIS: begin
                    if (ok_ev) begin nxt = M_EXIT; nerr = 0; end
                    else if (er_ev) begin nerr = inc; if (reach) nxt = M_LOCK; end
                end
                M_EXIT, M_ENTRY: begin
                    if (ok_ev) begin nxt = M_DIS; nerr = 0; end
                    else begin
                        if (er_ev) nerr = inc;
                        if (er_ev && reach) nxt = M_ALARM;
                        else if (expd) nxt = (m_state == M_EXIT) ? M_ARMED : M_ALARM;
                    end
                end
                M_ARMED: begin
                    if (ok_ev) begin nxt = M_DIS; nerr = 0; end
                    else begin
                        if (er_ev) nerr = inc;
                        if (er_ev && reach) nxt = M_ALARM;
                        else if (sh2) nxt = M_ENTRY;
                    end
                end
                M_ALARM: begin
                    if (ok_ev) begin nxt = M_DIS; nerr = 0; end
                    else begin
                        if (er_ev) nerr = (inc > P_MAX) ? P_MAX : inc;
                        if (expd) begin nxt = M_ARMED; nerr = 0; end
                    end
                end
                default: begin
                    if (expd) begin nxt = M_DIS; nerr = 0; end
                end
            endcase
            if (nxt != m_state) begin
                $display("cycle %0d: state %0d -> %0d err=%0d", m_cycle, m_state, nxt, nerr);
                m_deadline = (dur_of(nxt) > 0) ? m_cycle + dur_of(nxt) * P_TICK : -1;
            end
            m_state = nxt;
            m_err   = nerr;
            kh3 = kh2;
            kh2 = kh1;
            kh1 = (k == 2'd1) ? 2'd3 : k;
            sh2 = sh1;
            sh1 = s;
        end
    endtask

    // ---------------------------------------------------------------- checks
    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cycle);
        end
    endtask

    task automatic compare_all();
        check_val("state",    int'(state),    m_state);
        check_val("errCount", int'(errCount), m_err);
        check_val("siren",    int'(siren),    int'(m_state == M_ALARM));
        check_val("armed",    int'(armed),
                  int'(m_state == M_ARMED || m_state == M_ENTRY || m_state == M_ALARM));
        check_val("pending",  int'(pending),  int'(m_state == M_EXIT || m_state == M_ENTRY));
        check_val("lockout",  int'(lockout),  int'(m_state == M_LOCK));
    endtask

    task automatic tick(input logic [1:0] k, input logic s, input logic r);
        keyStatus = k;
        sensor    = s;
        reset     = r;
        @(posedge clk);
        model_step(k, s, r);
        #1;
        compare_all();
    endtask

    task automatic arm_seq();
        repeat (3) tick(2'd0, 1'b0, 1'b0);
        repeat (8) tick(2'd3, 1'b0, 1'b0);
        check_val("arm_seq_state", int'(state), M_ARMED);
    endtask

    task automatic trip_seq();
        repeat (3) tick(2'd3, 1'b1, 1'b0);
        check_val("trip_state", int'(state), M_ENTRY);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int         trans;
        int         prev_st;
        int         hold;
        int         r;
        logic [1:0] k;
        logic       s;

        // Reset
        tick(2'd3, 1'b0, 1'b1);
        tick(2'd3, 1'b0, 1'b1);
        check_val("rst_state",    int'(state),    0);
        check_val("rst_siren",    int'(siren),    0);
        check_val("rst_armed",    int'(armed),    0);
        check_val("rst_pending",  int'(pending),  0);
        check_val("rst_lockout",  int'(lockout),  0);
        check_val("rst_errCount", int'(errCount), 0);

        // Arm and disarm
        tick(2'd0, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 1'b0);
        check_val("arm_edge2_state", int'(state), 0);
        tick(2'd0, 1'b0, 1'b0);
        check_val("arm_edge3_pending", int'(pending), 1);
        check_val("arm_edge3_state",   int'(state),   1);
        repeat (7) tick(2'd3, 1'b0, 1'b0);
        check_val("exit_7_state", int'(state), 1);
        tick(2'd3, 1'b0, 1'b0);
        check_val("exit_8_state", int'(state), 2);
        check_val("exit_8_armed", int'(armed), 1);
        repeat (3) tick(2'd0, 1'b0, 1'b0);
        check_val("disarm_state", int'(state), 0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // Entry alarm
        arm_seq();
        trip_seq();
        repeat (11) tick(2'd3, 1'b0, 1'b0);
        check_val("entry_11_state", int'(state), 3);
        tick(2'd3, 1'b0, 1'b0);
        check_val("entry_12_state", int'(state), 4);
        check_val("entry_12_siren", int'(siren), 1);
        repeat (3) tick(2'd0, 1'b0, 1'b0);
        check_val("alarm_ok_siren", int'(siren), 0);
        check_val("alarm_ok_state", int'(state), 0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // Lockout
        for (int g = 1; g <= 3; g++) begin
            tick(2'd2, 1'b0, 1'b0);
            tick(2'd3, 1'b0, 1'b0);
            tick(2'd3, 1'b0, 1'b0);
            check_val("lock_errCount", int'(errCount), g);
            tick(2'd3, 1'b0, 1'b0);
        end
        check_val("lock_state",   int'(state),   5);
        check_val("lock_lockout", int'(lockout), 1);
        repeat (3) tick(2'd0, 1'b0, 1'b0);
        check_val("lock_ok_ignored", int'(state), 5);
        tick(2'd3, 1'b0, 1'b0);
        repeat (14) tick(2'd3, 1'b0, 1'b0);
        check_val("lock_19_state", int'(state), 5);
        tick(2'd3, 1'b0, 1'b0);
        check_val("lock_20_state",    int'(state),    0);
        check_val("lock_20_errCount", int'(errCount), 0);

        // Held result fires once
        arm_seq();
        repeat (3) tick(2'd3, 1'b0, 1'b0);
        trans = 0;
        for (int i = 0; i < 50; i++) begin
            prev_st = int'(state);
            tick(2'd0, 1'b0, 1'b0);
            if (int'(state) != prev_st) trans++;
        end
        check_val("held_transitions", trans, 1);
        check_val("held_state", int'(state), 0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // OK on the same edge as ENTRY_DELAY expiry
        arm_seq();
        trip_seq();
        repeat (9) tick(2'd3, 1'b0, 1'b0);
        repeat (2) tick(2'd0, 1'b0, 1'b0);
        check_val("prio_11_state", int'(state), 3);
        tick(2'd0, 1'b0, 1'b0);
        check_val("prio_state", int'(state), 0);
        check_val("prio_siren", int'(siren), 0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // Reset mid-ENTRY_DELAY with errCount=2
        arm_seq();
        trip_seq();
        repeat (2) begin
            tick(2'd2, 1'b0, 1'b0);
            repeat (3) tick(2'd3, 1'b0, 1'b0);
        end
        check_val("pre_rst_errCount", int'(errCount), 2);
        check_val("pre_rst_state",    int'(state),    3);
        tick(2'd3, 1'b0, 1'b1);
        check_val("mid_rst_state",    int'(state),    0);
        check_val("mid_rst_errCount", int'(errCount), 0);
        check_val("mid_rst_armed",    int'(armed),    0);
        check_val("mid_rst_pending",  int'(pending),  0);
        check_val("mid_rst_siren",    int'(siren),    0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // Siren timeout
        arm_seq();
        trip_seq();
        repeat (12) tick(2'd3, 1'b0, 1'b0);
        check_val("sto_alarm_state", int'(state), 4);
`ifdef SIREN_TIMEOUT_EN
        repeat (7) tick(2'd3, 1'b0, 1'b0);
        check_val("sto_7_state", int'(state), 4);
        tick(2'd3, 1'b0, 1'b0);
        check_val("sto_8_state", int'(state), 2);
        check_val("sto_8_siren", int'(siren), 0);
`else
        repeat (100) tick(2'd3, 1'b0, 1'b0);
        check_val("sto_100_siren", int'(siren), 1);
        check_val("sto_100_state", int'(state), 4);
`endif
        repeat (3) tick(2'd0, 1'b0, 1'b0);
        check_val("sto_disarm_state", int'(state), 0);
        repeat (3) tick(2'd3, 1'b0, 1'b0);

        // Randomized phase
        hold = 0;
        k    = 2'd3;
        s    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                if (r < 55) begin
                    k = 2'd3; hold = $urandom_range(1, 40);
                end else if (r < 62) begin
                    k = 2'd1; hold = $urandom_range(1, 5);
                end else if (r < 80) begin
                    k = 2'd0; hold = $urandom_range(1, 6);
                end else begin
                    k = 2'd2; hold = $urandom_range(1, 6);
                end
            end
            hold--;
            if ($urandom_range(0, 24) == 0) s = ~s;
            tick(k, s, ($urandom_range(0, 599) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
